// File: rtl/header_dispatcher.sv
// Buffers a block header, streams it byte-by-byte to a UART transmitter, then
// assembles the little-endian response nonce. Optional response timeout: HDR_TIMEOUT_EN.
module header_dispatcher #(
  parameter int HDR_BYTES      = 80,
  parameter int NONCE_BYTES    = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        start,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [31:0] nonce,
  output logic        nonce_valid,
  output logic        timeout
);

  localparam int IDX_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam int CNT_W = $clog2(NONCE_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NONCE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SEND, HOLD, DRAIN, RECV} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [31:0]      asm_q, asm_d;
  logic [31:0]      nonce_q, nonce_d;
  logic             nonce_valid_q, nonce_valid_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       hdr_mem [HDR_BYTES];
  logic             mem_we;
  logic             tx_fire;

`ifdef HDR_TIMEOUT_EN
  logic [31:0]      timer_q, timer_d;
`else
  logic             unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  assign mem_we  = wr_en && (state_q == IDLE) && (32'(wr_addr) < HDR_BYTES);
  assign tx_fire = (state_q == SEND) && !tx_busy;

  // The header buffer is deliberately outside the reset domain so a reset
  // during dispatch leaves the loaded header ready for a retry.
  always_ff @(posedge clk) begin
    if (mem_we) hdr_mem[IDX_W'(wr_addr)] <= wr_data;
  end

  // tx_data shows the new byte in the pulse cycle and is then held by tx_data_q.
  assign tx_start    = tx_fire;
  assign tx_data     = tx_fire ? hdr_mem[idx_q] : tx_data_q;
  assign busy        = (state_q != IDLE);
  assign nonce       = nonce_q;
  assign nonce_valid = nonce_valid_q;
  assign timeout     = timeout_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    asm_d         = asm_q;
    nonce_d       = nonce_q;
    nonce_valid_d = 1'b0;
    timeout_d     = 1'b0;
`ifdef HDR_TIMEOUT_EN
    timer_d       = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
          cnt_d   = '0;
          asm_d   = '0;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_d = hdr_mem[idx_q];
          state_d   = HOLD;
        end
      end
      HOLD: state_d = DRAIN;
      DRAIN: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = RECV;
`ifdef HDR_TIMEOUT_EN
            timer_d = '0;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      RECV: begin
        // Bytes collect in a shadow register so nonce only ever shows a complete value.
        if (rx_ready) begin
          for (int i = 0; i < 4; i++) begin
            if (cnt_q == CNT_W'(i)) asm_d[i*8 +: 8] = rx_data;
          end
          cnt_d = cnt_q + 1'b1;
`ifdef HDR_TIMEOUT_EN
          timer_d = '0;
`endif
          if (cnt_q == LAST_CNT) begin
            nonce_d       = asm_d;
            nonce_valid_d = 1'b1;
            cnt_d         = '0;
            state_d       = IDLE;
          end
        end
`ifdef HDR_TIMEOUT_EN
        else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          timer_d   = '0;
          cnt_d     = '0;
          asm_d     = '0;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      asm_q         <= '0;
      nonce_q       <= '0;
      nonce_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef HDR_TIMEOUT_EN
      timer_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      asm_q         <= asm_d;
      nonce_q       <= nonce_d;
      nonce_valid_q <= nonce_valid_d;
      timeout_q     <= timeout_d;
`ifdef HDR_TIMEOUT_EN
      timer_q       <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_header_dispatcher.sv
// Directed bench for header_dispatcher with a 10-cycle-per-byte UART busy model.
// Define HDR_TIMEOUT_EN to exercise the response timeout with TIMEOUT_CYCLES=100.
module tb_header_dispatcher;

  localparam int HDR = 80;
`ifdef HDR_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 1000;
`endif

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] nonce;
  logic        nonce_valid;
  logic        timeout;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int          sent_cnt  = 0;
  int          nv_cnt    = 0;
  int          to_cnt    = 0;
  int          busy_cnt  = 0;
  logic        pend      = 1'b0;
  logic [7:0]  last_tx   = 8'h00;
  logic [7:0]  exp_hdr [HDR];

  header_dispatcher #(
    .HDR_BYTES(HDR),
    .NONCE_BYTES(4),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .busy(busy),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .nonce(nonce),
    .nonce_valid(nonce_valid),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs from a negedge, returns just after the sampling edge.
  task automatic applyStimulus(input logic s_start, input logic s_wr, input logic [6:0] s_addr,
                               input logic [7:0] s_wdata, input logic s_rx, input logic [7:0] s_rxd);
    @(negedge clk);
    start    = s_start;
    wr_en    = s_wr;
    wr_addr  = s_addr;
    wr_data  = s_wdata;
    rx_ready = s_rx;
    rx_data  = s_rxd;
    @(posedge clk);
    #1;
    start    = 1'b0;
    wr_en    = 1'b0;
    rx_ready = 1'b0;
  endtask

  task automatic waitSent(input int n);
    int guard = 0;
    while (sent_cnt < n && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("tx_count", sent_cnt, n);
  endtask

  // Leaves the caller at the negedge where tx_busy drops after the last byte,
  // i.e. one edge before the DRAIN->RECV transition.
  task automatic waitRecvEntry();
    int guard = 0;
    while (!(sent_cnt >= HDR && tx_busy) && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    while (tx_busy && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("recv_entry_sent", sent_cnt, HDR);
    checkOutput("recv_entry_busy", tx_busy, 1'b0);
  endtask

  // Byte-order/stability monitor plus the UART busy model (busy starts the cycle after a pulse).
  always @(negedge clk) begin
    if (reset) begin
      if (tx_start) begin
        if (sent_cnt < HDR) checkOutput("tx_byte", tx_data, exp_hdr[sent_cnt]);
        else checkOutput("tx_extra_pulse", sent_cnt, HDR - 1);
        checkOutput("tx_while_busy", tx_busy, 1'b0);
        last_tx = tx_data;
        sent_cnt++;
      end else if (busy && sent_cnt > 0) begin
        checkOutput("tx_data_hold", tx_data, last_tx);
      end
      if (nonce_valid) nv_cnt++;
      if (timeout) to_cnt++;
    end
    if (!reset) begin
      busy_cnt = 0;
      pend     = 1'b0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (pend) begin
        busy_cnt = 10;
        pend     = 1'b0;
      end
      if (tx_start) pend = 1'b1;
    end
    tx_busy = (busy_cnt != 0);
  end

  initial begin
    logic [7:0] rx_seq [4];
    reset    = 1'b0;
    start    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rx_ready = 1'b0;
    rx_data  = '0;
    for (int i = 0; i < HDR; i++) exp_hdr[i] = 8'(i);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_tx_start", tx_start, 1'b0);
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_nonce", nonce, 32'h0);
    checkOutput("rst_nonce_valid", nonce_valid, 1'b0);
    checkOutput("rst_timeout", timeout, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < HDR; i++) applyStimulus(1'b0, 1'b1, 7'(i), 8'(i), 1'b0, 8'h00);

    $display("[TB] dispatch 1: full header, ignored start/rx/write, nonce 0x12345678");
    sent_cnt = 0;
    applyStimulus(1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 8'h00);
    checkOutput("start_latency", tx_start, 1'b1);
    checkOutput("first_byte", tx_data, 8'h00);
    checkOutput("busy_after_start", busy, 1'b1);
    waitSent(3);
    applyStimulus(1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'hAA);
    waitRecvEntry();
    rx_ready = 1'b1;
    rx_data  = 8'h99;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 7'd5, 8'hFF, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h78);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h56);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h34);
    checkOutput("partial_nonce_hidden", nonce, 32'h0);
    checkOutput("recv_busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h12);
    checkOutput("nonce_valid_latency", nonce_valid, 1'b1);
    checkOutput("nonce_value_1", nonce, 32'h12345678);
    checkOutput("busy_after_nonce", busy, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("nonce_valid_single", nonce_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h55);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("nonce_hold_idle", nonce, 32'h12345678);
    checkOutput("nv_count_1", nv_cnt, 1);
    checkOutput("sent_total_1", sent_cnt, HDR);

    $display("[TB] dispatch 2: reset abort at byte 40");
    sent_cnt = 0;
    applyStimulus(1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 8'h00);
    waitSent(40);
    reset = 1'b0;
    #1;
    checkOutput("abort_tx_start", tx_start, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_tx_data", tx_data, 8'h00);
    checkOutput("abort_nonce", nonce, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("abort_no_pulse", sent_cnt, 40);
    reset = 1'b1;

    $display("[TB] dispatch 3: resend from byte 0, nonce 0xDEADBEEF");
    sent_cnt = 0;
    applyStimulus(1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 8'h00);
    checkOutput("restart_first_byte", tx_data, 8'h00);
    waitRecvEntry();
    rx_seq[0] = 8'hEF;
    rx_seq[1] = 8'hBE;
    rx_seq[2] = 8'hAD;
    rx_seq[3] = 8'hDE;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, rx_seq[i]);
    checkOutput("nonce_valid_3", nonce_valid, 1'b1);
    checkOutput("nonce_value_3", nonce, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    checkOutput("nv_count_3", nv_cnt, 2);

    $display("[TB] dispatch 4: two response bytes then silence");
    sent_cnt = 0;
    applyStimulus(1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 8'h00);
    waitRecvEntry();
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h22);
`ifdef HDR_TIMEOUT_EN
    begin
      int cyc = 0;
      while (!timeout && cyc < 300) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      checkOutput("timeout_latency", cyc, 100);
    end
    checkOutput("timeout_busy", busy, 1'b0);
    checkOutput("timeout_no_valid", nonce_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("timeout_single", timeout, 1'b0);
    checkOutput("timeout_nonce_kept", nonce, 32'hDEADBEEF);
    checkOutput("timeout_count", to_cnt, 1);
    checkOutput("nv_count_4", nv_cnt, 2);
`else
    repeat (200) @(posedge clk);
    #1;
    checkOutput("no_timeout_busy", busy, 1'b1);
    checkOutput("no_timeout_count", to_cnt, 0);
    checkOutput("wait_nonce_kept", nonce, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h33);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h44);
    checkOutput("nonce_value_4", nonce, 32'h44332211);
    checkOutput("busy_after_4", busy, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("nv_count_4", nv_cnt, 3);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
